if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32 pipeline. Owns the PC and drives the combinational instruction-memory address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall requests from the hazard unit (load-use hazard) and PC redirects from branch/jump resolution in EX.
- Counts committed fetches for debug.

---
 rtl/if_stage.sv | 100 ++++++++++
 tb/tb_if_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID pipeline register, handling stalls, redirects and a fetch counter.
module if_stage #(
    parameter int unsigned          DATAWIDTH  = 32,
    parameter logic [DATAWIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned          IMEM_BYTES = 1024,
    parameter logic [31:0]          NOP_INST   = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [DATAWIDTH-1:0] redirect_pc_i,
    output logic [DATAWIDTH-1:0] imem_addr_o,
    input  logic [31:0]          imem_inst_i,
    output logic [DATAWIDTH-1:0] ifid_pc_o,
    output logic [DATAWIDTH-1:0] ifid_pc4_o,
    output logic [31:0]          ifid_inst_o,
    output logic                 ifid_valid_o,
    output logic                 misalign_o,
    output logic [31:0]          fetch_cnt_o
);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [DATAWIDTH-1:0] pc, pc_nxt, pc_plus4;
    logic [DATAWIDTH-1:0] ifid_pc_nxt, ifid_pc4_nxt;
    logic [31:0]          ifid_inst_nxt, fetch_cnt_nxt;
    logic                 ifid_valid_nxt, misalign_nxt, in_range;

    // The address comes straight from the PC register, so stall/redirect never reach it.
    assign imem_addr_o = pc;
    assign pc_plus4    = pc + DATAWIDTH'(4);
    assign in_range    = pc < DATAWIDTH'(IMEM_BYTES);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            ifid_pc_o    <= '0;
            ifid_pc4_o   <= DATAWIDTH'(4);
            ifid_inst_o  <= NOP_INST;
            ifid_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            fetch_cnt_o  <= '0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            ifid_pc_o    <= ifid_pc_nxt;
            ifid_pc4_o   <= ifid_pc4_nxt;
            ifid_inst_o  <= ifid_inst_nxt;
            ifid_valid_o <= ifid_valid_nxt;
            misalign_o   <= misalign_nxt;
            fetch_cnt_o  <= fetch_cnt_nxt;
        end
    end

    // Next-state logic; BOOT and RUN share the redirect > stall > advance priority.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        ifid_pc_nxt    = ifid_pc_o;
        ifid_pc4_nxt   = ifid_pc4_o;
        ifid_inst_nxt  = ifid_inst_o;
        ifid_valid_nxt = ifid_valid_o;
        misalign_nxt   = misalign_o;
        fetch_cnt_nxt  = fetch_cnt_o;

        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase

        if (redirect_i) begin
            pc_nxt         = {redirect_pc_i[DATAWIDTH-1:2], 2'b00};
            ifid_pc_nxt    = pc;
            ifid_pc4_nxt   = pc_plus4;
            ifid_inst_nxt  = NOP_INST;
            ifid_valid_nxt = 1'b0;
            if (redirect_pc_i[1:0] != 2'b00) begin
                misalign_nxt = 1'b1;
            end
        end else if (!stall_i) begin
            pc_nxt         = pc_plus4;
            ifid_pc_nxt    = pc;
            ifid_pc4_nxt   = pc_plus4;
            ifid_inst_nxt  = in_range ? imem_inst_i : NOP_INST;
            ifid_valid_nxt = in_range;
            if (in_range) begin
                fetch_cnt_nxt = fetch_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a reference model pushes expected IF/ID state per
// cycle into a scoreboard queue; a monitor pops and compares after every rising edge.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int unsigned IMEM = 24;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifpc4;
        logic [31:0] inst;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    logic        clk, rst_n, stall, redirect;
    logic [31:0] redirect_pc, imem_addr, imem_inst;
    logic [31:0] ifid_pc, ifid_pc4, ifid_inst, fetch_cnt;
    logic        ifid_valid, misalign;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    exp_t m;

    if_stage #(
        .DATAWIDTH (32),
        .RESET_PC  (32'h0),
        .IMEM_BYTES(IMEM),
        .NOP_INST  (NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_addr_o  (imem_addr),
        .imem_inst_i  (imem_inst),
        .ifid_pc_o    (ifid_pc),
        .ifid_pc4_o   (ifid_pc4),
        .ifid_inst_o  (ifid_inst),
        .ifid_valid_o (ifid_valid),
        .misalign_o   (misalign),
        .fetch_cnt_o  (fetch_cnt)
    );

    // Program image: addi/sw/addi/add/lw/add at 0..20, then filler words.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h00A0_0493;
            32'd4:   return 32'h0091_A023;
            32'd8:   return 32'h0014_8493;
            32'd12:  return 32'h0094_84B3;
            32'd16:  return 32'h0001_A503;
            32'd20:  return 32'h00A4_8533;
            default: return 32'hC0DE_0000 | a;
        endcase
    endfunction

    assign imem_inst = mem_word(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard monitor: one expectation per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks += 7;
                if (imem_addr !== e.pc) begin n_fail++; $display("FAIL sb_pc: got %h want %h", imem_addr, e.pc); end
                if (ifid_pc !== e.ifpc) begin n_fail++; $display("FAIL sb_ifid_pc: got %h want %h", ifid_pc, e.ifpc); end
                if (ifid_pc4 !== e.ifpc4) begin n_fail++; $display("FAIL sb_ifid_pc4: got %h want %h", ifid_pc4, e.ifpc4); end
                if (ifid_inst !== e.inst) begin n_fail++; $display("FAIL sb_ifid_inst: got %h want %h", ifid_inst, e.inst); end
                if (ifid_valid !== e.valid) begin n_fail++; $display("FAIL sb_valid: got %b want %b", ifid_valid, e.valid); end
                if (misalign !== e.mis) begin n_fail++; $display("FAIL sb_misalign: got %b want %b", misalign, e.mis); end
                if (fetch_cnt !== e.cnt) begin n_fail++; $display("FAIL sb_fetch_cnt: got %0d want %0d", fetch_cnt, e.cnt); end
            end
        end
    end

    // Drive one cycle, update the reference model and queue its expectation.
    task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] t);
        @(negedge clk);
        rst_n = r; stall = s; redirect = d; redirect_pc = t;
        if (!r) begin
            m.pc = 32'h0; m.ifpc = 32'h0; m.ifpc4 = 32'd4; m.inst = NOP;
            m.valid = 1'b0; m.mis = 1'b0; m.cnt = 32'd0;
        end else if (d) begin
            m.ifpc = m.pc; m.ifpc4 = m.pc + 32'd4; m.inst = NOP; m.valid = 1'b0;
            if (t[1:0] != 2'b00) m.mis = 1'b1;
            m.pc = {t[31:2], 2'b00};
        end else if (!s) begin
            m.ifpc  = m.pc;
            m.ifpc4 = m.pc + 32'd4;
            m.valid = (m.pc < 32'(IMEM));
            m.inst  = m.valid ? mem_word(m.pc) : NOP;
            if (m.valid) m.cnt = m.cnt + 32'd1;
            m.pc = m.pc + 32'd4;
        end
        q.push_back(m);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 5;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        if (ifid_pc4 !== 32'd4) begin n_fail++; $display("FAIL reset_pc4: got %h want 4", ifid_pc4); end
        if (ifid_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", ifid_inst, NOP); end
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
        if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt); end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            n_checks += 2;
            if (ifid_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL run_pc%0d: got %h want %h", i, ifid_pc, 32'(4 * i)); end
            if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL run_valid%0d: got %b want 1", i, ifid_valid); end
            if (i == 0) begin
                n_checks++;
                if (ifid_inst !== 32'h00A0_0493) begin n_fail++; $display("FAIL run_first_inst: got %h want 00a00493", ifid_inst); end
            end
        end
        n_checks++;
        if (fetch_cnt !== 32'd6) begin n_fail++; $display("FAIL run_cnt: got %0d want 6", fetch_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            n_checks += 4;
            if (imem_addr !== 32'd20) begin n_fail++; $display("FAIL stall_addr: got %h want 14", imem_addr); end
            if (ifid_pc !== 32'd16) begin n_fail++; $display("FAIL stall_ifid_pc: got %h want 10", ifid_pc); end
            if (ifid_inst !== 32'h0001_A503) begin n_fail++; $display("FAIL stall_inst: got %h want 0001a503", ifid_inst); end
            if (fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d want 5", fetch_cnt); end
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks += 2;
        if (ifid_pc !== 32'd20) begin n_fail++; $display("FAIL unstall_pc: got %h want 14", ifid_pc); end
        if (fetch_cnt !== 32'd6) begin n_fail++; $display("FAIL unstall_cnt: got %0d want 6", fetch_cnt); end
    endtask

    task automatic test_redirect_stall();
        drive(1'b1, 1'b1, 1'b1, 32'd8);
        n_checks += 3;
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b want 0", ifid_valid); end
        if (ifid_inst !== NOP) begin n_fail++; $display("FAIL redir_inst: got %h want %h", ifid_inst, NOP); end
        if (imem_addr !== 32'd8) begin n_fail++; $display("FAIL redir_addr: got %h want 8", imem_addr); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks += 2;
        if (ifid_pc !== 32'd8) begin n_fail++; $display("FAIL redir_target_pc: got %h want 8", ifid_pc); end
        if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL redir_target_valid: got %b want 1", ifid_valid); end
    endtask

    task automatic test_misalign();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_000E);
        n_checks += 2;
        if (imem_addr !== 32'd12) begin n_fail++; $display("FAIL mis_addr: got %h want c", imem_addr); end
        if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_set: got %b want 1", misalign); end
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_sticky: got %b want 1", misalign); end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        n_checks++;
        if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misalign); end
    endtask

    task automatic test_out_of_range();
        do_reset();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks += 4;
        if (ifid_pc !== 32'd24) begin n_fail++; $display("FAIL oor_pc: got %h want 18", ifid_pc); end
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL oor_valid: got %b want 0", ifid_valid); end
        if (ifid_inst !== NOP) begin n_fail++; $display("FAIL oor_inst: got %h want %h", ifid_inst, NOP); end
        if (fetch_cnt !== 32'd6) begin n_fail++; $display("FAIL oor_cnt: got %0d want 6", fetch_cnt); end
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks += 3;
        if (ifid_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want fffffffc", ifid_pc); end
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_valid: got %b want 0", ifid_valid); end
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks += 2;
        if (ifid_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_fetch_pc: got %h want 0", ifid_pc); end
        if (fetch_cnt !== 32'd7) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 7", fetch_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'd8);
        n_checks += 4;
        if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_addr: got %h want 0", imem_addr); end
        if (ifid_pc !== 32'h0) begin n_fail++; $display("FAIL mid_ifid_pc: got %h want 0", ifid_pc); end
        if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", ifid_valid); end
        if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d want 0", fetch_cnt); end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_checks += 2;
        if (ifid_pc !== 32'h0) begin n_fail++; $display("FAIL boot_pc: got %h want 0", ifid_pc); end
        if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL boot_valid: got %b want 1", ifid_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  32'($urandom_range(0, 40)));
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        m = '{pc: 32'h0, ifpc: 32'h0, ifpc4: 32'd4, inst: NOP, valid: 1'b0, mis: 1'b0, cnt: 32'd0};
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d want 0 pending", q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
